// File: rtl/avl_pkg.sv
// Shared types and helpers for the Avalon-MM burst master.
package avl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_BEAT,
    DONE
  } avl_state_e;

  // Per-request flags captured at accept time
  typedef struct packed {
    logic write;
    logic err;
  } avl_req_flags_t;

  // Zero-length requests run one beat; oversize requests are cut to the line size
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_burst);
    int unsigned res;
    res = len;
    if (len == 0) res = 1;
    else if (len > max_burst) res = max_burst;
    return res;
  endfunction

endpackage

// File: rtl/avl_line_buffer.sv
// Line register: beat-indexed write for read data, beat-indexed read mux, parallel load.
module avl_line_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned BC_W      = 3,
  localparam int unsigned LINE_W   = DATA_W * MAX_BURST
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [LINE_W-1:0] line_in,
  input  logic              wr_en,
  input  logic [BC_W-1:0]   wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BC_W-1:0]   rd_idx,
  output logic [DATA_W-1:0] rd_data_c,
  output logic [LINE_W-1:0] line
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      line <= '0;
    end else if (load) begin
      line <= line_in;
    end else if (wr_en) begin
      for (int i = 0; i < int'(MAX_BURST); i++) begin
        if (wr_idx == BC_W'(i)) line[i*DATA_W +: DATA_W] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(MAX_BURST); i++) begin
      if (rd_idx == BC_W'(i)) rd_data_c = line[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/avl_burst_master.sv
// Avalon-MM pipelined burst master: runs one line read or write request as a single burst.
module avl_burst_master
  import avl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 1024,
  localparam int unsigned BC_W     = $clog2(MAX_BURST) + 1,
  localparam int unsigned BE_W     = DATA_W / 8,
  localparam int unsigned LINE_W   = DATA_W * MAX_BURST
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BC_W-1:0]   req_len,
  input  logic [BE_W-1:0]   req_be,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [LINE_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] av_address,
  output logic [BE_W-1:0]   av_byteenable,
  output logic              av_read,
  output logic              av_write,
  input  logic              av_waitrequest,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_readdatavalid,
  output logic [DATA_W-1:0] av_writedata,
  output logic [BC_W-1:0]   av_burstcount,
  output logic              av_beginbursttransfer
);

  localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  avl_state_e     state_q, state_d;
  avl_req_flags_t flags_q, flags_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   len_q, len_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [BC_W-1:0]   beat_q, beat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              ready_d, rd_d, wr_d, begin_d, rvalid_d, rerr_d;
  logic [BE_W-1:0]   be_out_d;
  logic [DATA_W-1:0] wdata_out_d;
  logic              buf_load, buf_wr;
  logic [DATA_W-1:0] buf_rd_c;

  avl_line_buffer #(
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST),
    .BC_W     (BC_W)
  ) u_line (
    .clk      (clk),
    .resetn   (resetn),
    .load     (buf_load),
    .line_in  (req_wdata),
    .wr_en    (buf_wr),
    .wr_idx   (beat_q),
    .wr_data  (av_readdata),
    .rd_idx   (beat_d),
    .rd_data_c(buf_rd_c),
    .line     (resp_rdata)
  );

  assign av_address    = addr_q;
  assign av_burstcount = len_q;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, captured request and next registered outputs
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    addr_d      = addr_q;
    len_d       = len_q;
    be_d        = be_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    begin_d     = 1'b0;
    buf_load    = 1'b0;
    buf_wr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d        = req_addr & ~ADDR_W'(BE_W - 1);
          len_d         = BC_W'(clamp_len(32'(req_len), MAX_BURST));
          be_d          = req_be;
          flags_d.write = req_write;
          flags_d.err   = 1'b0;
          beat_d        = '0;
          tmo_d         = '0;
          begin_d       = 1'b1;
          buf_load      = req_write;
          state_d       = req_write ? WR_BEAT : RD_CMD;
        end
      end
      RD_CMD, RD_DATA: begin
        if (state_q == RD_CMD && !av_waitrequest) state_d = RD_DATA;
        if (av_readdatavalid) begin
          buf_wr = 1'b1;
          tmo_d  = '0;
          if (beat_q == len_q - BC_W'(1)) state_d = DONE;
          else                            beat_d  = beat_q + BC_W'(1);
        end else if (state_q == RD_DATA && TIMEOUT != 0) begin
          // Counter reaching TIMEOUT idle cycles abandons the burst
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT)) begin
            state_d     = DONE;
            flags_d.err = 1'b1;
          end
        end
      end
      WR_BEAT: begin
        if (!av_waitrequest) begin
          if (beat_q == len_q - BC_W'(1)) state_d = DONE;
          else                            beat_d  = beat_q + BC_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d  = (state_d == IDLE);
    rd_d     = (state_d == RD_CMD);
    wr_d     = (state_d == WR_BEAT);
    rvalid_d = (state_d == DONE);
    rerr_d   = (state_d == DONE) && flags_d.err;

    be_out_d = av_byteenable;
    if (state_d == RD_CMD)  be_out_d = '1;
    if (state_d == WR_BEAT) be_out_d = be_d;

    // Beat 0 comes straight from the request since the buffer loads on the same edge
    wdata_out_d = av_writedata;
    if (state_d == WR_BEAT) wdata_out_d = (state_q == IDLE) ? req_wdata[DATA_W-1:0] : buf_rd_c;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      flags_q               <= '0;
      addr_q                <= '0;
      len_q                 <= '0;
      be_q                  <= '0;
      beat_q                <= '0;
      tmo_q                 <= '0;
      req_ready             <= 1'b1;
      av_read               <= 1'b0;
      av_write              <= 1'b0;
      av_byteenable         <= '0;
      av_writedata          <= '0;
      av_beginbursttransfer <= 1'b0;
      resp_valid            <= 1'b0;
      resp_err              <= 1'b0;
    end else begin
      flags_q               <= flags_d;
      addr_q                <= addr_d;
      len_q                 <= len_d;
      be_q                  <= be_d;
      beat_q                <= beat_d;
      tmo_q                 <= tmo_d;
      req_ready             <= ready_d;
      av_read               <= rd_d;
      av_write              <= wr_d;
      av_byteenable         <= be_out_d;
      av_writedata          <= wdata_out_d;
      av_beginbursttransfer <= begin_d;
      resp_valid            <= rvalid_d;
      resp_err              <= rerr_d;
    end
  end

endmodule

// File: tb/tb_avl_burst_master.sv
// Randomised bench for avl_burst_master with a behavioural slave and line model.
module tb_avl_burst_master;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr;
  logic [2:0]   req_len;
  logic [3:0]   req_be;
  logic [127:0] req_wdata;
  logic         resp_valid, resp_err;
  logic [127:0] resp_rdata;
  logic [31:0]  av_address;
  logic [3:0]   av_byteenable;
  logic         av_read, av_write, av_waitrequest;
  logic [31:0]  av_readdata;
  logic         av_readdatavalid;
  logic [31:0]  av_writedata;
  logic [2:0]   av_burstcount;
  logic         av_beginbursttransfer;

  avl_burst_master #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .av_address(av_address), .av_byteenable(av_byteenable),
    .av_read(av_read), .av_write(av_write), .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .av_writedata(av_writedata), .av_burstcount(av_burstcount),
    .av_beginbursttransfer(av_beginbursttransfer)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference line contents as seen on resp_rdata
  logic [31:0] model_line [4];

  logic [31:0]  o_addr;
  logic [2:0]   o_bc;
  logic [3:0]   o_be;
  logic         o_err;
  logic [127:0] o_rdata;
  int o_begin_cnt, o_begin_bad, o_resp_cnt, o_resp_cyc, o_last_cyc, o_stall_cnt, o_stall_bad;
  bit o_hung;
  logic [31:0] wq [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] model_packed();
    return {model_line[3], model_line[2], model_line[1], model_line[0]};
  endfunction

  function automatic int eff_len(input logic [2:0] len);
    return (len == 3'd0) ? 1 : ((len > 3'd4) ? 4 : int'(len));
  endfunction

  // Drives one request and acts as the Avalon slave; records what the master did
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                         input logic [3:0] be, input logic [127:0] line, input int give,
                         input int gap_max, input int wait_beat, input int wait_n);
    int cyc, wbeat, given, gap_left, wait_left, after;
    logic cmd_done, wreq;
    o_begin_cnt = 0; o_begin_bad = 0; o_resp_cnt = 0; o_resp_cyc = -1; o_last_cyc = -1;
    o_stall_cnt = 0; o_stall_bad = 0; o_hung = 1; o_err = 1'bx; o_rdata = 'x;
    o_addr = 'x; o_bc = 'x; o_be = 'x;
    wq.delete();
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len; req_be = be;
    req_wdata = line; av_waitrequest = 1'b0; av_readdatavalid = 1'b0;
    cyc = 0; wbeat = 0; given = 0; gap_left = 0; wait_left = wait_n; cmd_done = 1'b0; after = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      cyc++;
      req_valid = 1'b0;
      av_readdatavalid = 1'b0;
      if (av_beginbursttransfer) begin
        o_begin_cnt++;
        if (cyc != 1) o_begin_bad++;
      end
      if (av_read || av_write) begin
        o_addr = av_address; o_bc = av_burstcount; o_be = av_byteenable;
      end
      if (resp_valid) begin
        o_resp_cnt++; o_resp_cyc = cyc; o_err = resp_err; o_rdata = resp_rdata;
        if (after < 0) after = 2;
      end
      if (av_write && wbeat == 1) begin
        o_stall_cnt++;
        if (av_writedata !== line[63:32]) o_stall_bad++;
      end
      if (cmd_done && given < give) begin
        if (gap_left > 0) gap_left--;
        else begin
          av_readdatavalid = 1'b1;
          av_readdata = line[given*32 +: 32];
          given++;
          o_last_cyc = cyc;
          gap_left = int'($urandom_range(gap_max, 0));
        end
      end
      wreq = 1'b0;
      if ((av_read || av_write) && (av_write ? wbeat : 0) == wait_beat && wait_left > 0) begin
        wreq = 1'b1;
        wait_left--;
      end
      av_waitrequest = wreq;
      if (av_write && !wreq) begin
        wq.push_back(av_writedata);
        wbeat++;
      end
      if (av_read && !wreq) cmd_done = 1'b1;
      if (after > 0) begin
        after--;
        if (after == 0) begin
          o_hung = 0;
          break;
        end
      end
    end
    av_readdatavalid = 1'b0;
    av_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    req_be = '0; req_wdata = '0; av_waitrequest = 1'b0; av_readdata = '0; av_readdatavalid = 1'b0;
    repeat (3) tick();
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
    total++; if ({av_read, av_write, av_beginbursttransfer, resp_valid, resp_err} !== 5'b0)
      $display("FAIL reset_strobes: got %b want 00000", {av_read, av_write, av_beginbursttransfer, resp_valid, resp_err});
    else passed++;
    total++; if ({av_address, av_writedata, av_burstcount} !== 67'b0)
      $display("FAIL reset_cmd: got addr %h wd %h bc %0d want 0", av_address, av_writedata, av_burstcount);
    else passed++;
    total++; if (resp_rdata !== 128'b0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else passed++;
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) model_line[i] = '0;
  endtask

  task automatic test_read_full();
    logic [127:0] line;
    line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    run_txn(1'b0, 32'h103, 3'd4, 4'h0, line, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) model_line[i] = line[i*32 +: 32];
    total++; if (o_hung) $display("FAIL rd_full_done: no response within budget"); else passed++;
    total++; if (o_addr !== 32'h100) $display("FAIL rd_full_addr: got %h want 00000100", o_addr); else passed++;
    total++; if (o_bc !== 3'd4) $display("FAIL rd_full_bc: got %0d want 4", o_bc); else passed++;
    total++; if (o_be !== 4'hF) $display("FAIL rd_full_be: got %h want f", o_be); else passed++;
    total++; if (o_begin_cnt !== 1 || o_begin_bad !== 0)
      $display("FAIL rd_full_begin: got %0d pulses (%0d late) want 1", o_begin_cnt, o_begin_bad);
    else passed++;
    total++; if (o_rdata !== model_packed()) $display("FAIL rd_full_rdata: got %h want %h", o_rdata, model_packed()); else passed++;
    total++; if (o_err !== 1'b0) $display("FAIL rd_full_err: got %b want 0", o_err); else passed++;
    total++; if (o_resp_cyc !== o_last_cyc + 1) $display("FAIL rd_full_lat: got cyc %0d want %0d", o_resp_cyc, o_last_cyc + 1); else passed++;
  endtask

  task automatic test_write_stall();
    logic [127:0] line;
    line = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    run_txn(1'b1, 32'h2000, 3'd2, 4'h3, line, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) model_line[i] = line[i*32 +: 32];
    total++; if (wq.size() !== 2) $display("FAIL wr_stall_beats: got %0d want 2", wq.size());
    else if (wq[0] !== 32'h11111111 || wq[1] !== 32'h22222222)
      $display("FAIL wr_stall_data: got %h %h want 11111111 22222222", wq[0], wq[1]);
    else passed++;
    total++; if (o_stall_cnt !== 4 || o_stall_bad !== 0)
      $display("FAIL wr_stall_hold: got %0d cycles (%0d wrong) want 4", o_stall_cnt, o_stall_bad);
    else passed++;
    total++; if (o_begin_cnt !== 1 || o_begin_bad !== 0)
      $display("FAIL wr_stall_begin: got %0d pulses (%0d late) want 1", o_begin_cnt, o_begin_bad);
    else passed++;
    total++; if (o_resp_cnt !== 1) $display("FAIL wr_stall_resp: got %0d pulses want 1", o_resp_cnt); else passed++;
    total++; if (o_be !== 4'h3 || o_bc !== 3'd2) $display("FAIL wr_stall_cmd: got be %h bc %0d want 3/2", o_be, o_bc); else passed++;
    total++; if (o_resp_cyc !== 2 + 1 + 3) $display("FAIL wr_stall_lat: got %0d want 6", o_resp_cyc); else passed++;
  endtask

  task automatic test_len_clamp();
    logic [2:0] lens [2];
    int         exp_bc [2];
    logic [127:0] line;
    lens[0] = 3'd0; lens[1] = 3'd7; exp_bc[0] = 1; exp_bc[1] = 4;
    for (int t = 0; t < 2; t++) begin
      line = {$urandom, $urandom, $urandom, $urandom};
      run_txn(1'b0, $urandom, lens[t], 4'h0, line, exp_bc[t], 1, 0, 0);
      for (int i = 0; i < exp_bc[t]; i++) model_line[i] = line[i*32 +: 32];
      total++; if (int'(o_bc) !== exp_bc[t]) $display("FAIL clamp_bc len=%0d: got %0d want %0d", lens[t], o_bc, exp_bc[t]); else passed++;
      total++; if (o_rdata !== model_packed()) $display("FAIL clamp_rdata len=%0d: got %h want %h", lens[t], o_rdata, model_packed()); else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [127:0] line;
    logic [31:0]  old1;
    old1 = model_line[1];
    line = {$urandom, $urandom, $urandom, $urandom};
    run_txn(1'b0, 32'h40, 3'd2, 4'h0, line, 1, 0, 0, 0);
    model_line[0] = line[31:0];
    total++; if (o_hung || o_err !== 1'b1) $display("FAIL tmo_err: got %b (hung %0d) want 1", o_err, o_hung); else passed++;
    total++; if (o_resp_cyc !== o_last_cyc + 1 + TMO)
      $display("FAIL tmo_lat: got cyc %0d want %0d", o_resp_cyc, o_last_cyc + 1 + TMO);
    else passed++;
    total++; if (o_rdata[31:0] !== line[31:0] || o_rdata[63:32] !== old1)
      $display("FAIL tmo_slots: got %h %h want %h %h", o_rdata[63:32], o_rdata[31:0], old1, line[31:0]);
    else passed++;
    total++; if (o_resp_cnt !== 1) $display("FAIL tmo_resp: got %0d pulses want 1", o_resp_cnt); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int bad_resp, bad_ready, bad_data;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500; req_len = 3'd4;
    av_waitrequest = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    av_readdatavalid = 1'b1; av_readdata = 32'hDEAD0000;
    tick();
    av_readdata = 32'hDEAD0001; resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) model_line[i] = '0;
    total++; if ({av_read, av_write, av_beginbursttransfer, resp_valid} !== 4'b0 || req_ready !== 1'b1)
      $display("FAIL rst_mid_state: got strobes %b ready %b want 0000/1", {av_read, av_write, av_beginbursttransfer, resp_valid}, req_ready);
    else passed++;
    total++; if (resp_rdata !== model_packed()) $display("FAIL rst_mid_rdata: got %h want 0", resp_rdata); else passed++;
    bad_resp = 0; bad_ready = 0; bad_data = 0;
    for (int i = 0; i < 4; i++) begin
      av_readdata = $urandom;
      tick();
      if (resp_valid) bad_resp++;
      if (!req_ready || av_read) bad_ready++;
      if (resp_rdata !== model_packed()) bad_data++;
    end
    av_readdatavalid = 1'b0;
    total++; if (bad_resp !== 0) $display("FAIL rst_mid_noresp: got %0d pulses want 0", bad_resp); else passed++;
    total++; if (bad_ready !== 0 || bad_data !== 0)
      $display("FAIL rst_mid_late: got %0d busy, %0d buffer writes want 0", bad_ready, bad_data);
    else passed++;
  endtask

  task automatic test_random();
    logic         wr;
    logic [31:0]  addr;
    logic [2:0]   len;
    logic [3:0]   be;
    logic [127:0] line;
    int L, wb, wn, bad;
    for (int n = 0; n < 16; n++) begin
      wr = 1'($urandom_range(1, 0)); addr = $urandom; len = 3'($urandom_range(7, 0));
      be = 4'($urandom_range(15, 1)); line = {$urandom, $urandom, $urandom, $urandom};
      L = eff_len(len);
      wb = wr ? int'($urandom_range(L - 1, 0)) : 0;
      wn = int'($urandom_range(3, 0));
      run_txn(wr, addr, len, be, line, wr ? 0 : L, 2, wb, wn);
      if (wr) for (int i = 0; i < 4; i++) model_line[i] = line[i*32 +: 32];
      else    for (int i = 0; i < L; i++) model_line[i] = line[i*32 +: 32];
      total++; if (o_hung || o_resp_cnt !== 1 || o_err !== 1'b0)
        $display("FAIL rnd%0d_resp: got %0d pulses err %b want 1/0", n, o_resp_cnt, o_err);
      else passed++;
      total++; if (int'(o_bc) !== L || o_addr !== {addr[31:2], 2'b00} || o_be !== (wr ? be : 4'hF))
        $display("FAIL rnd%0d_cmd: got bc %0d addr %h be %h want %0d %h %h", n, o_bc, o_addr, o_be, L, {addr[31:2], 2'b00}, wr ? be : 4'hF);
      else passed++;
      if (wr) begin
        bad = (wq.size() == L) ? 0 : 1;
        for (int i = 0; i < wq.size() && i < 4; i++) if (wq[i] !== line[i*32 +: 32]) bad++;
        total++; if (bad !== 0) $display("FAIL rnd%0d_wdata: got %0d bad beats of %0d want 0", n, bad, wq.size()); else passed++;
        total++; if (o_resp_cyc !== L + 1 + wn) $display("FAIL rnd%0d_wlat: got %0d want %0d", n, o_resp_cyc, L + 1 + wn); else passed++;
      end else begin
        total++; if (o_rdata !== model_packed()) $display("FAIL rnd%0d_rdata: got %h want %h", n, o_rdata, model_packed()); else passed++;
        total++; if (o_resp_cyc !== o_last_cyc + 1) $display("FAIL rnd%0d_rlat: got %0d want %0d", n, o_resp_cyc, o_last_cyc + 1); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int nresp, adj, overlap;
    logic prev;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    req_valid = 1'b1; req_write = 1'b1; req_len = 3'd1; req_be = 4'hF;
    req_addr = 32'h800; req_wdata = {$urandom, $urandom, $urandom, $urandom};
    av_waitrequest = 1'b0;
    nresp = 0; adj = 0; overlap = 0; prev = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (resp_valid) begin
        nresp++;
        if (prev) adj++;
      end
      prev = resp_valid;
      if (req_ready && (av_write || resp_valid)) overlap++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) model_line[i] = req_wdata[i*32 +: 32];
    repeat (3) tick();
    // One-beat write occupies accept, beat and done cycles: one response per 3 cycles
    total++; if (nresp !== 10) $display("FAIL b2b_count: got %0d responses want 10", nresp); else passed++;
    total++; if (adj !== 0) $display("FAIL b2b_adjacent: got %0d adjacent pulses want 0", adj); else passed++;
    total++; if (overlap !== 0) $display("FAIL b2b_ready: got %0d busy-ready cycles want 0", overlap); else passed++;
  endtask

  initial begin
    test_reset();
    test_read_full();
    test_write_stall();
    test_len_clamp();
    test_timeout();
    test_reset_mid_burst();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
